// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory target for the pipeline's MEM-stage request interface.  It
// accepts one load/store request at a time on a valid/ready request channel,
// waits a programmable number of cycles, and answers on a valid/ready
// response channel.  Storage is word addressed and is not cleared by reset.
//
// Parameters:
//   ADDR_W  - word-address width; storage depth is 2**ADDR_W words
//   DATA_W  - data width; must be 32 (four byte lanes)
//   LATENCY - edges from request acceptance to response valid (1..15)
//
// Ports:
//   i_clk, i_rst_n         - clock (rising edge), async active-low reset
//   i_req_valid/o_req_ready- request handshake
//   i_req_we               - 1 = store, 0 = load
//   i_req_addr             - 32-bit word address
//   i_req_wdata, i_req_be  - store data and per-byte enables
//   o_resp_valid/i_resp_ready - response handshake
//   o_resp_rdata           - load data (0 for stores)
//   o_resp_err             - address error flag
//   o_busy                 - a request is accepted and not yet retired
//
// Optional feature (macro DMEM_RANGE_CHECK_EN):
//   When defined, a request whose upper address bits [31:ADDR_W] are not all
//   zero performs no memory access and is answered with o_resp_err=1 and
//   rdata 32'hDEADBEEF.  When undefined, the upper bits are ignored, so
//   addresses alias modulo 2**ADDR_W and o_resp_err is always 0.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [31:0]       i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [3:0]        i_req_be,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_resp_err,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              accept;
    logic              access_now;
    logic              retire;
    logic              in_range;
    logic [ADDR_W-1:0] idx;

    assign idx        = addr_q[ADDR_W-1:0];
    assign accept     = (state_q == ST_IDLE) && i_req_valid;
    assign access_now = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign retire     = (state_q == ST_RESP) && i_resp_ready;

`ifdef DMEM_RANGE_CHECK_EN
    // Any set bit above the storage index marks the request as out of range.
    assign in_range = (addr_q[31:ADDR_W] == '0);
`else
    // Upper address bits are deliberately ignored so accesses alias.
    logic unused_upper_addr;
    assign in_range          = 1'b1;
    assign unused_upper_addr = |addr_q[31:ADDR_W];
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the counter reaching zero in WAIT marks the edge at
    // which the memory access happens and the response becomes visible.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_req_valid)     state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 4'd0)   state_d = ST_RESP;
            ST_RESP: if (i_resp_ready)    state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decode straight from the state, so an
    // asynchronous reset clears o_resp_valid without waiting for a clock.
    always_comb begin
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_busy       = 1'b0;
        unique case (state_q)
            ST_IDLE: o_req_ready = 1'b1;
            ST_WAIT: o_busy      = 1'b1;
            ST_RESP: begin
                o_resp_valid = 1'b1;
                o_busy       = 1'b1;
            end
            default: o_req_ready = 1'b1;
        endcase
    end

    // Request capture and latency counter.  Request inputs are only looked at
    // on the acceptance edge; afterwards the latched copy drives the access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'd0;
        end else if (accept) begin
            cnt_q   <= CNT_LOAD;
            we_q    <= i_req_we;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            be_q    <= i_req_be;
        end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Response data/error registers.  They are loaded at the access edge and
    // hold until the requester takes the response, then return to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (access_now) begin
            err_q <= !in_range;
            if (!in_range) begin
                rdata_q <= DATA_W'(32'hDEADBEEF);
            end else if (we_q) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= mem[idx];
            end
        end else if (retire) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    // Storage write port.  Only enabled byte lanes change; a reset during
    // WAIT moves the FSM to IDLE first, so an uncommitted store never lands.
    always_ff @(posedge i_clk) begin
        if (access_now && we_q && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be_q[k]) begin
                    mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign o_resp_rdata = rdata_q;
    assign o_resp_err   = err_q;

endmodule
